// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and a 1-entry hold buffer for stalled responses.
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_d,
  input  logic        flush_d,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_REQ, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        kill_q, kill_d;
  logic        hold_full_q, hold_full_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        valid_d_q, valid_d_d;
  logic [31:0] instr_d_q, instr_d_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] pcplus4_d_q, pcplus4_d_d;

  logic        fire;
  logic        rsp_acc;
  logic        load;
  logic [31:0] load_data;
  logic [31:0] load_pc;

  always_comb begin
    state_d     = state_q;
    pc_f_d      = pc_f_q;
    req_pc_d    = req_pc_q;
    kill_d      = kill_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_pc_d   = hold_pc_q;
    valid_d_d   = valid_d_q;
    instr_d_d   = instr_d_q;
    pc_d_d      = pc_d_q;
    pcplus4_d_d = pcplus4_d_q;
    load        = 1'b0;
    load_data   = imem_rsp_data;
    load_pc     = req_pc_q;

    imem_req_valid = (state_q == S_REQ) & ~hold_full_q & ~redirect_valid;
    fire           = imem_req_valid & imem_req_ready;
    rsp_acc        = (state_q == S_WAIT) & imem_rsp_valid;

    if (redirect_valid) begin
      pc_f_d      = redirect_pc & ~32'h3;
      valid_d_d   = 1'b0;
      instr_d_d   = NOP;
      hold_full_d = 1'b0;
      if (state_q == S_WAIT) begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
          kill_d  = 1'b0;
        end else begin
          kill_d  = 1'b1;
        end
      end
    end else begin
      if (fire) begin
        req_pc_d = pc_f_q;
        pc_f_d   = pc_f_q + 32'd4;
        state_d  = S_WAIT;
      end
      if (rsp_acc) state_d = S_REQ;

      // Decode consumes IF/ID whenever it is not stalling; a bubble is the default refill.
      if (flush_d | ~stall_d) begin
        valid_d_d = 1'b0;
        instr_d_d = NOP;
      end
      if (flush_d) hold_full_d = 1'b0;

      if (rsp_acc) begin
        if (kill_q) begin
          kill_d = 1'b0;
        end else if (flush_d | ~valid_d_q | ~stall_d) begin
          load = 1'b1;
        end else begin
          hold_full_d = 1'b1;
          hold_data_d = imem_rsp_data;
          hold_pc_d   = req_pc_q;
        end
      end else if (~flush_d & hold_full_q & ~stall_d) begin
        load        = 1'b1;
        load_data   = hold_data_q;
        load_pc     = hold_pc_q;
        hold_full_d = 1'b0;
      end

      if (load) begin
        valid_d_d   = 1'b1;
        instr_d_d   = load_data;
        pc_d_d      = load_pc;
        pcplus4_d_d = load_pc + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_f_q      <= RESET_PC;
      req_pc_q    <= '0;
      kill_q      <= 1'b0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_pc_q   <= '0;
      valid_d_q   <= 1'b0;
      instr_d_q   <= NOP;
      pc_d_q      <= '0;
      pcplus4_d_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_f_q      <= pc_f_d;
      req_pc_q    <= req_pc_d;
      kill_q      <= kill_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_pc_q   <= hold_pc_d;
      valid_d_q   <= valid_d_d;
      instr_d_q   <= instr_d_d;
      pc_d_q      <= pc_d_d;
      pcplus4_d_q <= pcplus4_d_d;
    end
  end

  assign imem_req_addr = pc_f_q;
  assign valid_d       = valid_d_q;
  assign instr_d       = instr_d_q;
  assign pc_d          = pc_d_q;
  assign pcplus4_d     = pcplus4_d_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q + {31'd0, load};
    perf_stall_d = perf_stall_q + {31'd0, stall_d & valid_d_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus a randomized stream checked
// against a queue-based model of the fetch/decode contract.
module tb_fetch_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic        ready;
  logic [31:0] imem_req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        flush;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_d        (stall),
    .flush_d        (flush),
    .valid_d        (valid_d),
    .instr_d        (instr_d),
    .pc_d           (pc_d),
    .pcplus4_d      (pcplus4_d)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; stall = 1'b0; flush = 1'b0;
    tick; tick;
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid_d); end
    checks++; if (instr_d !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", instr_d, NOP); end
    checks++; if (pc_d !== 32'h0) begin errors++; $display("FAIL reset_pc_d got %h want 0", pc_d); end
    checks++; if (pcplus4_d !== 32'h0) begin errors++; $display("FAIL reset_pcplus4 got %h want 0", pcplus4_d); end
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_req_valid got %0b want 1", imem_req_valid); end
    checks++; if (imem_req_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", imem_req_addr, RESET_PC); end
  endtask

  task automatic test_basic;
    do_reset;
    ready = 1'b1; #1;
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL basic_addr0 got %h want 0", imem_req_addr); end
    tick;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL basic_wait_noreq got %0b want 0", imem_req_valid); end
    rsp_valid = 1'b1; rsp_data = 32'h0050_0093;
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (valid_d !== 1'b1 || instr_d !== 32'h0050_0093) begin errors++; $display("FAIL basic_instr got %0b/%h want 1/00500093", valid_d, instr_d); end
    checks++; if (pc_d !== 32'h0 || pcplus4_d !== 32'h4) begin errors++; $display("FAIL basic_pc got %h/%h want 0/4", pc_d, pcplus4_d); end
    checks++; if (imem_req_addr !== 32'h4 || imem_req_valid !== 1'b1) begin errors++; $display("FAIL basic_addr4 got %h/%0b want 4/1", imem_req_addr, imem_req_valid); end
    tick;
    rsp_valid = 1'b1; rsp_data = 32'h0010_0113;
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (imem_req_addr !== 32'h8) begin errors++; $display("FAIL basic_addr8 got %h want 8", imem_req_addr); end
    checks++; if (pc_d !== 32'h4 || instr_d !== 32'h0010_0113) begin errors++; $display("FAIL basic_second got %h/%h want 4/00100113", pc_d, instr_d); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    ready = 1'b1;
    tick;
    ready = 1'b0; reset = 1'b1;
    tick;
    reset = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b want 0", valid_d); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin errors++; $display("FAIL rstmid_restart got %0b/%h want 1/%h", imem_req_valid, imem_req_addr, RESET_PC); end
  endtask

  task automatic test_stall_hold;
    do_reset;
    ready = 1'b1; stall = 1'b1;
    tick;
    rsp_valid = 1'b1; rsp_data = 32'h1111_1111;
    tick;
    rsp_valid = 1'b0;
    tick;
    rsp_valid = 1'b1; rsp_data = 32'h2222_2222;
    tick;
    rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_noreq[%0d] got %0b want 0", i, imem_req_valid); end
      checks++; if (valid_d !== 1'b1 || instr_d !== 32'h1111_1111 || pc_d !== 32'h0) begin errors++; $display("FAIL stall_frozen[%0d] got %0b/%h/%h want 1/11111111/0", i, valid_d, instr_d, pc_d); end
      tick;
    end
    stall = 1'b0; #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL stall_release_noreq got %0b want 0", imem_req_valid); end
    tick;
    checks++; if (valid_d !== 1'b1 || instr_d !== 32'h2222_2222 || pc_d !== 32'h4 || pcplus4_d !== 32'h8) begin errors++; $display("FAIL stall_drain got %0b/%h/%h/%h want 1/22222222/4/8", valid_d, instr_d, pc_d, pcplus4_d); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin errors++; $display("FAIL stall_resume got %0b/%h want 1/8", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait;
    do_reset;
    ready = 1'b1;
    tick;
    ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick;
    redirect_valid = 1'b0;
    checks++; if (valid_d !== 1'b0 || instr_d !== NOP) begin errors++; $display("FAIL redir_inval got %0b/%h want 0/NOP", valid_d, instr_d); end
    rsp_valid = 1'b1; rsp_data = 32'hBAD0_BAD0;
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL redir_drop got %0b want 0", valid_d); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %0b/%h want 1/100", imem_req_valid, imem_req_addr); end
    ready = 1'b1;
    tick;
    ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0030_0193;
    tick;
    rsp_valid = 1'b0;
    checks++; if (valid_d !== 1'b1 || instr_d !== 32'h0030_0193 || pc_d !== 32'h100 || pcplus4_d !== 32'h104) begin errors++; $display("FAIL redir_target got %0b/%h/%h/%h want 1/00300193/100/104", valid_d, instr_d, pc_d, pcplus4_d); end
  endtask

  task automatic test_redirect_coincident;
    do_reset;
    ready = 1'b1;
    tick;
    ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hBAD1_BAD1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick;
    rsp_valid = 1'b0; redirect_valid = 1'b0; #1;
    checks++; if (valid_d !== 1'b0) begin errors++; $display("FAIL coinc_drop got %0b want 0", valid_d); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin errors++; $display("FAIL coinc_addr got %0b/%h want 1/200", imem_req_valid, imem_req_addr); end
    ready = 1'b1;
    tick;
    ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0040_0213;
    tick;
    rsp_valid = 1'b0;
    checks++; if (valid_d !== 1'b1 || instr_d !== 32'h0040_0213 || pc_d !== 32'h200) begin errors++; $display("FAIL coinc_deliver got %0b/%h/%h want 1/00400213/200", valid_d, instr_d, pc_d); end
  endtask

  task automatic test_wrap;
    do_reset;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; ready = 1'b1; #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_redir_noreq got %0b want 0", imem_req_valid); end
    tick;
    redirect_valid = 1'b0; #1;
    checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h want fffffffc", imem_req_addr); end
    tick;
    ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0050_0293;
    tick;
    rsp_valid = 1'b0; #1;
    checks++; if (pc_d !== 32'hFFFF_FFFC || pcplus4_d !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h/%h want fffffffc/0", pc_d, pcplus4_d); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 0", imem_req_addr); end
  endtask

  task automatic test_flush;
    do_reset;
    ready = 1'b1; stall = 1'b1;
    tick;
    rsp_valid = 1'b1; rsp_data = 32'h3333_3333;
    tick;
    rsp_valid = 1'b0;
    tick;
    rsp_valid = 1'b1; rsp_data = 32'h4444_4444;
    tick;
    rsp_valid = 1'b0; ready = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0; #1;
    checks++; if (valid_d !== 1'b0 || instr_d !== NOP) begin errors++; $display("FAIL flush_inval got %0b/%h want 0/NOP", valid_d, instr_d); end
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin errors++; $display("FAIL flush_pc got %0b/%h want 1/8", imem_req_valid, imem_req_addr); end
    ready = 1'b1;
    tick;
    ready = 1'b0; flush = 1'b1;
    tick;
    flush = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h5555_5555;
    tick;
    rsp_valid = 1'b0;
    checks++; if (valid_d !== 1'b1 || instr_d !== 32'h5555_5555 || pc_d !== 32'h8) begin errors++; $display("FAIL flush_inflight got %0b/%h/%h want 1/55555555/8", valid_d, instr_d, pc_d); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      ready = 1'b1;
      tick;
      ready = 1'b0; rsp_valid = 1'b1; rsp_data = $urandom;
      tick;
      rsp_valid = 1'b0;
    end
    stall = 1'b1;
    tick; tick;
    stall = 1'b0; #1;
    checks++; if (perf_fetch_cnt !== 32'd3) begin errors++; $display("FAIL perf_fetch got %0d want 3", perf_fetch_cnt); end
    checks++; if (perf_stall_cnt !== 32'd2) begin errors++; $display("FAIL perf_stall got %0d want 2", perf_stall_cnt); end
  endtask
`endif

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  // Model: words owed to decode, in order; at most two (IF/ID + hold) may be owed.
  task automatic test_random_stream;
    ent_t        q[$];
    ent_t        e;
    bit          outstanding, killed, exp_rv, fire, consume, drain;
    int unsigned lat;
    logic [31:0] exp_pc, rsp_pc;
    do_reset;
    exp_pc = RESET_PC; rsp_pc = '0; outstanding = 0; killed = 0; lat = 0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      drain          = (cyc >= 650);
      stall          = drain ? 1'b0 : ($urandom_range(0, 2) == 0);
      ready          = drain ? 1'b0 : 1'($urandom_range(0, 1));
      redirect_valid = !drain && ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      flush          = !drain && ($urandom_range(0, 19) == 0);
      rsp_valid      = outstanding && (lat == 0);
      rsp_data       = $urandom;
      #1;
      exp_rv = !redirect_valid && !outstanding && (q.size() < 2);
      checks++; if (imem_req_valid !== exp_rv) begin errors++; $display("FAIL rnd_req_valid cyc %0d got %0b want %0b", cyc, imem_req_valid, exp_rv); end
      if (exp_rv) begin
        checks++; if (imem_req_addr !== exp_pc) begin errors++; $display("FAIL rnd_addr cyc %0d got %h want %h", cyc, imem_req_addr, exp_pc); end
      end
      checks++; if (valid_d !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %0b want %0b", cyc, valid_d, q.size() != 0); end
      if (q.size() != 0) begin
        checks++;
        if (instr_d !== q[0].data || pc_d !== q[0].pc || pcplus4_d !== q[0].pc + 32'd4) begin
          errors++;
          $display("FAIL rnd_ifid cyc %0d got %h/%h/%h want %h/%h/%h", cyc, instr_d, pc_d, pcplus4_d, q[0].data, q[0].pc, q[0].pc + 32'd4);
        end
      end else begin
        checks++; if (instr_d !== NOP) begin errors++; $display("FAIL rnd_nop cyc %0d got %h want %h", cyc, instr_d, NOP); end
      end
      fire    = exp_rv && ready;
      consume = (q.size() != 0) && !stall;
      if (consume) void'(q.pop_front());
      if (redirect_valid || flush) q.delete();
      if (rsp_valid) begin
        outstanding = 0;
        if (killed) killed = 0;
        else if (!redirect_valid) begin
          e.data = rsp_data; e.pc = rsp_pc;
          q.push_back(e);
        end
      end else if (outstanding) begin
        if (redirect_valid) killed = 1;
        if (lat > 0) lat--;
      end
      if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      else if (fire) begin
        outstanding = 1; rsp_pc = exp_pc; exp_pc = exp_pc + 32'd4;
        lat = $urandom_range(0, 3);
      end
      if (q.size() > 2) begin
        checks++; errors++;
        $display("FAIL rnd_capacity cyc %0d got %0d owed want <=2", cyc, q.size());
        q.delete();
      end
      tick;
    end
    rsp_valid = 1'b0;
    checks++; if (q.size() != 0 || outstanding) begin errors++; $display("FAIL rnd_drain got owed=%0d outstanding=%0b want 0/0", q.size(), outstanding); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_reset_mid;
    test_stall_hold;
    test_redirect_wait;
    test_redirect_coincident;
    test_wrap;
    test_flush;
`ifdef FETCH_PERF_EN
    test_perf;
`endif
    test_random_stream;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
